// File: rtl/bus_txn_if.sv
// Request/response handshake between a transaction requester and the bus
// controller; the shared tristate bus itself stays on plain inout ports.
interface bus_txn_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_src;
    logic [1:0] req_dest;
    logic [1:0] req_op;
    logic [7:0] req_len;
    logic       ack;
    logic       done;
    logic       err;
    logic       busy;
    logic [7:0] byte_count;

    modport master (
        output req_valid, req_src, req_dest, req_op, req_len,
        input  req_ready, ack, done, err, busy, byte_count
    );

    modport slave (
        input  req_valid, req_src, req_dest, req_op, req_len,
        output req_ready, ack, done, err, busy, byte_count
    );
endinterface

// File: rtl/bus_txn_ctrl.sv
// Controller-side initiator for the shared 8-bit bus: issues the header,
// waits out the turnaround, counts payload bytes and broadcasts ack.
module bus_txn_ctrl #(
    parameter int unsigned TURNAROUND = 3,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    bus_txn_if.slave   txn,
    inout  wire  [7:0] bus_data,
    inout  wire        bus_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_WAIT,
        S_DATA,
        S_ACK
    } state_t;

    localparam logic [3:0] TURN_LAST = 4'(TURNAROUND - 1);
    localparam logic [7:0] IDLE_MAX  = 8'(TIMEOUT);

    state_t     state_q, state_d;
    logic [1:0] src_q, src_d;
    logic [1:0] dest_q, dest_d;
    logic [1:0] op_q, op_d;
    logic [7:0] len_q, len_d;
    logic       err_q, err_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] idle_q, idle_d;
    logic [3:0] turn_q, turn_d;

    logic       busDrive;
    logic       busValidSeen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            src_q   <= 2'b00;
            dest_q  <= 2'b00;
            op_q    <= 2'b00;
            len_q   <= 8'd0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
            idle_q  <= 8'd0;
            turn_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dest_q  <= dest_d;
            op_q    <= op_d;
            len_q   <= len_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
            turn_q  <= turn_d;
        end
    end

    assign busValidSeen = (bus_valid == 1'b1);

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dest_d  = dest_q;
        op_d    = op_q;
        len_d   = len_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        idle_d  = idle_q;
        turn_d  = turn_q;

        unique case (state_q)
            S_IDLE: begin
                if (txn.req_valid) begin
                    src_d  = txn.req_src;
                    dest_d = txn.req_dest;
                    op_d   = txn.req_op;
                    len_d  = txn.req_len;
                    cnt_d  = 8'd0;
                    idle_d = 8'd0;
                    turn_d = 4'd0;
                    // Self-addressed or controller-sourced requests never reach the bus.
                    if (txn.req_src == 2'b11 || txn.req_src == txn.req_dest) begin
                        err_d   = 1'b1;
                        state_d = S_ACK;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_HEADER;
                    end
                end
            end
            S_HEADER: begin
                turn_d  = 4'd0;
                state_d = (len_q == 8'd0) ? S_ACK : S_WAIT;
            end
            S_WAIT: begin
                idle_d = 8'd0;
                if (turn_q == TURN_LAST) begin
                    state_d = S_DATA;
                end else begin
                    turn_d = turn_q + 4'd1;
                end
            end
            S_DATA: begin
                // A byte arriving always takes precedence over the idle timeout.
                if (busValidSeen) begin
                    idle_d = 8'd0;
                    if (cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                    if (cnt_q + 8'd1 == len_q) begin
                        state_d = S_ACK;
                    end
                end else begin
                    idle_d = idle_q + 8'd1;
                    if (idle_q + 8'd1 == IDLE_MAX) begin
                        err_d   = 1'b1;
                        state_d = S_ACK;
                    end
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busDrive = (state_q == S_HEADER);

    assign bus_data  = busDrive ? {2'b00, dest_q, src_q, op_q} : 8'bz;
    assign bus_valid = busDrive ? 1'b1 : 1'bz;

    assign txn.req_ready  = (state_q == S_IDLE) && rst_n;
    assign txn.ack        = (state_q == S_ACK);
    assign txn.done       = (state_q == S_ACK);
    assign txn.err        = (state_q == S_ACK) && err_q;
    assign txn.busy       = (state_q != S_IDLE);
    assign txn.byte_count = cnt_q;

endmodule
